mem_access_stage: RTL and testbench

Memory-access stage of the JOF32 pipeline, sitting between execute and write-back. It accepts one operation per handshake from execute, performs loads and stores on the data memory over a req/ack handshake, and stalls execute while an access is outstanding. It registers the MEM/WB pipeline outputs `result_mem`, `result_alu`, `sel_wb`, `reg_wr` and `dir_wb`, which drive the write-back stage directly.

---
 rtl/jof32_mem_pkg.sv | 19 +
 rtl/mem_wb_reg.sv | 53 +++++
 rtl/mem_access_stage.sv | 163 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/jof32_mem_pkg.sv
// Shared types and widths for the JOF32 memory-access stage.
package jof32_mem_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 32;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic                  sel_wb;
    logic                  reg_wr;
    logic [REG_ADDR_W-1:0] dir_wb;
    logic [DATA_W-1:0]     result_alu;
  } wb_ctl_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB register bank: loads an op when ld=1, otherwise inserts a bubble
// (valid and reg_wr cleared, data fields hold). One cycle, no backpressure.
module mem_wb_reg
  import jof32_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld,
  input  wb_ctl_t               ctl_in,
  input  logic [DATA_W-1:0]     mem_in,
  output logic                  wb_valid,
  output logic [DATA_W-1:0]     wb_result_mem,
  output logic [DATA_W-1:0]     wb_result_alu,
  output logic                  wb_sel_wb,
  output logic                  wb_reg_wr,
  output logic [REG_ADDR_W-1:0] wb_dir_wb
);

  logic              valid_q, valid_d;
  wb_ctl_t           ctl_q, ctl_d;
  logic [DATA_W-1:0] mem_q, mem_d;

  always_comb begin
    valid_d      = ld;
    ctl_d        = ctl_q;
    ctl_d.reg_wr = 1'b0;
    mem_d        = mem_q;
    if (ld) begin
      ctl_d = ctl_in;
      mem_d = mem_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctl_q   <= '0;
      mem_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctl_q   <= ctl_d;
      mem_q   <= mem_d;
    end
  end

  assign wb_valid      = valid_q;
  assign wb_result_mem = mem_q;
  assign wb_result_alu = ctl_q.result_alu;
  assign wb_sel_wb     = ctl_q.sel_wb;
  assign wb_reg_wr     = ctl_q.reg_wr;
  assign wb_dir_wb     = ctl_q.dir_wb;

endmodule

// File: rtl/mem_access_stage.sv
// JOF32 memory-access stage: ALU ops 1 cycle, loads/stores >=2 cycles; ex_ready low while an access is outstanding.
// MEM_TIMEOUT_EN adds an ack timeout that abandons the access and sets sticky mem_err.
module mem_access_stage
  import jof32_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [DATA_W-1:0]     ex_alu_result,
  input  logic [DATA_W-1:0]     ex_store_data,
  input  logic                  ex_mem_rd,
  input  logic                  ex_mem_wr,
  input  logic                  ex_sel_wb,
  input  logic                  ex_reg_wr,
  input  logic [REG_ADDR_W-1:0] ex_dir_wb,
  input  logic                  flush,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  wb_valid,
  output logic [DATA_W-1:0]     wb_result_mem,
  output logic [DATA_W-1:0]     wb_result_alu,
  output logic                  wb_sel_wb,
  output logic                  wb_reg_wr,
  output logic [REG_ADDR_W-1:0] wb_dir_wb,
  output logic                  mem_err
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  mem_state_e        state_q, state_d;
  logic              req_q, req_d, we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
  wb_ctl_t           pend_q, pend_d;
  logic              wb_ld;
  wb_ctl_t           wb_ctl;
  logic [DATA_W-1:0] wb_mem;
  logic              accept, timeout;

  assign ex_ready = (state_q == IDLE) && !rst;
  assign accept   = ex_valid && ex_ready;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign timeout = (state_q == WAIT_ACK) && !dmem_ack &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Held at zero in IDLE, so it starts from zero on every entry to WAIT_ACK.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | timeout;
    if (state_q == IDLE) cnt_d = '0;
    else if (!dmem_ack)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign mem_err = err_q;
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pend_d  = pend_q;
    wb_ld   = 1'b0;
    wb_ctl  = pend_q;
    wb_mem  = '0;
    case (state_q)
      IDLE: begin
        if (accept && !flush) begin
          if (ex_mem_rd || ex_mem_wr) begin
            req_d   = 1'b1;
            we_d    = ex_mem_wr;
            addr_d  = ex_alu_result;
            wdata_d = ex_store_data;
            pend_d  = '{sel_wb: ex_sel_wb, reg_wr: ex_reg_wr & ~ex_mem_wr,
                        dir_wb: ex_dir_wb, result_alu: ex_alu_result};
            state_d = WAIT_ACK;
          end else begin
            wb_ld  = 1'b1;
            wb_ctl = '{sel_wb: ex_sel_wb, reg_wr: ex_reg_wr,
                       dir_wb: ex_dir_wb, result_alu: ex_alu_result};
          end
        end
      end
      WAIT_ACK: begin
        if (dmem_ack) begin
          req_d   = 1'b0;
          wb_ld   = 1'b1;
          wb_mem  = we_q ? '0 : dmem_rdata;
          state_d = IDLE;
        end else if (timeout) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pend_q  <= pend_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

  mem_wb_reg u_mem_wb_reg (
    .clk           (clk),
    .rst           (rst),
    .ld            (wb_ld),
    .ctl_in        (wb_ctl),
    .mem_in        (wb_mem),
    .wb_valid      (wb_valid),
    .wb_result_mem (wb_result_mem),
    .wb_result_alu (wb_result_alu),
    .wb_sel_wb     (wb_sel_wb),
    .wb_reg_wr     (wb_reg_wr),
    .wb_dir_wb     (wb_dir_wb)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; timeout cases run only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_alu_result, ex_store_data;
  logic        ex_mem_rd, ex_mem_wr, ex_sel_wb, ex_reg_wr;
  logic [3:0]  ex_dir_wb;
  logic        flush;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_result_mem, wb_result_alu;
  logic        wb_sel_wb, wb_reg_wr;
  logic [3:0]  wb_dir_wb;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_sel_wb(ex_sel_wb), .ex_reg_wr(ex_reg_wr), .ex_dir_wb(ex_dir_wb),
    .flush(flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_result_mem(wb_result_mem), .wb_result_alu(wb_result_alu),
    .wb_sel_wb(wb_sel_wb), .wb_reg_wr(wb_reg_wr), .wb_dir_wb(wb_dir_wb),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic rd, input logic wr, input logic sel, input logic regwr,
                          input logic [3:0] dir, input logic [31:0] alu, input logic [31:0] data);
    ex_valid      = 1'b1;
    ex_mem_rd     = rd;
    ex_mem_wr     = wr;
    ex_sel_wb     = sel;
    ex_reg_wr     = regwr;
    ex_dir_wb     = dir;
    ex_alu_result = alu;
    ex_store_data = data;
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 0; ex_mem_rd = 0; ex_mem_wr = 0; ex_sel_wb = 0; ex_reg_wr = 0;
    ex_dir_wb = '0; ex_alu_result = '0; ex_store_data = '0; flush = 0;
    dmem_ack = 0; dmem_rdata = '0;

    // Reset state
    #3;
    check("rst_req", dmem_req, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_result_alu", wb_result_alu, 0);
    check("rst_mem_err", mem_err, 0);
    check("rst_ex_ready", ex_ready, 0);
    step();
    rst = 1'b0;
    #1;
    check("rel_ex_ready", ex_ready, 1);

    // ALU op
    drive_op(0, 0, 0, 1, 4'd5, 32'h0000_1234, 32'h0);
    step();
    ex_valid = 0;
    check("alu_wb_valid", wb_valid, 1);
    check("alu_result_alu", wb_result_alu, 32'h1234);
    check("alu_dir", wb_dir_wb, 5);
    check("alu_reg_wr", wb_reg_wr, 1);
    check("alu_result_mem", wb_result_mem, 0);
    check("alu_req", dmem_req, 0);
    step();
    check("bubble_valid", wb_valid, 0);
    check("bubble_reg_wr", wb_reg_wr, 0);
    check("bubble_hold_alu", wb_result_alu, 32'h1234);

    // Ack while idle is ignored
    dmem_ack = 1; dmem_rdata = 32'hFFFF_0000;
    step();
    dmem_ack = 0;
    check("idle_ack_valid", wb_valid, 0);
    check("idle_ack_req", dmem_req, 0);

    // Load with ack 3 cycles after request rises
    drive_op(1, 0, 1, 1, 4'd3, 32'h0000_0100, 32'h0);
    step();
    ex_valid = 0;
    check("ld_we", dmem_we, 0);
    for (int i = 0; i < 3; i++) begin
      check("ld_req", dmem_req, 1);
      check("ld_addr", dmem_addr, 32'h100);
      check("ld_ex_ready", ex_ready, 0);
      check("ld_wait_valid", wb_valid, 0);
      step();
    end
    dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
    check("ld_ack_ex_ready", ex_ready, 0);
    step();
    dmem_ack = 0; dmem_rdata = '0;
    check("ld_wb_valid", wb_valid, 1);
    check("ld_result_mem", wb_result_mem, 32'hDEAD_BEEF);
    check("ld_sel_wb", wb_sel_wb, 1);
    check("ld_dir", wb_dir_wb, 3);
    check("ld_reg_wr", wb_reg_wr, 1);
    check("ld_req_drop", dmem_req, 0);
    check("ld_ex_ready_back", ex_ready, 1);

    // Store with reg_wr requested; stage must suppress it
    drive_op(0, 1, 0, 1, 4'd7, 32'h0000_0200, 32'hA5A5_A5A5);
    step();
    ex_valid = 0; ex_store_data = '0;
    for (int i = 0; i < 2; i++) begin
      check("st_req", dmem_req, 1);
      check("st_we", dmem_we, 1);
      check("st_wdata", dmem_wdata, 32'hA5A5_A5A5);
      check("st_addr", dmem_addr, 32'h200);
      step();
    end
    dmem_ack = 1;
    step();
    dmem_ack = 0;
    check("st_wb_valid", wb_valid, 1);
    check("st_reg_wr", wb_reg_wr, 0);
    check("st_result_alu", wb_result_alu, 32'h200);
    check("st_result_mem", wb_result_mem, 0);

    // Flush on accepted load
    drive_op(1, 0, 1, 1, 4'd9, 32'h0000_0300, 32'h0);
    flush = 1;
    step();
    ex_valid = 0; flush = 0;
    check("fl_req", dmem_req, 0);
    check("fl_wb_valid", wb_valid, 0);
    check("fl_ex_ready", ex_ready, 1);
    step();
    check("fl_req2", dmem_req, 0);

    // Flush during WAIT_ACK has no effect
    drive_op(1, 0, 1, 1, 4'd4, 32'h0000_0400, 32'h0);
    step();
    ex_valid = 0; flush = 1;
    check("flw_req", dmem_req, 1);
    step();
    flush = 0;
    check("flw_req_held", dmem_req, 1);
    dmem_ack = 1; dmem_rdata = 32'h1234_5678;
    step();
    dmem_ack = 0;
    check("flw_wb_valid", wb_valid, 1);
    check("flw_result_mem", wb_result_mem, 32'h1234_5678);
    check("flw_dir", wb_dir_wb, 4);

`ifdef MEM_TIMEOUT_EN
    // Load with no ack times out after 4 request cycles
    drive_op(1, 0, 1, 1, 4'd6, 32'h0000_0500, 32'h0);
    step();
    ex_valid = 0;
    for (int i = 0; i < 4; i++) begin
      check("to_req", dmem_req, 1);
      check("to_err_low", mem_err, 0);
      step();
    end
    check("to_req_drop", dmem_req, 0);
    check("to_mem_err", mem_err, 1);
    check("to_bubble", wb_valid, 0);
    check("to_ex_ready", ex_ready, 1);
    drive_op(0, 0, 0, 1, 4'd2, 32'h0000_0055, 32'h0);
    step();
    ex_valid = 0;
    check("to_next_valid", wb_valid, 1);
    check("to_next_alu", wb_result_alu, 32'h55);
    check("to_err_sticky", mem_err, 1);
    #2 rst = 1;
    #1 check("to_err_rst", mem_err, 0);
    #2 rst = 0;

    // Ack in the timeout cycle wins
    step();
    drive_op(1, 0, 1, 1, 4'd8, 32'h0000_0510, 32'h0);
    step();
    ex_valid = 0;
    for (int i = 0; i < 3; i++) step();
    dmem_ack = 1; dmem_rdata = 32'hCAFE_F00D;
    step();
    dmem_ack = 0;
    check("toack_valid", wb_valid, 1);
    check("toack_result_mem", wb_result_mem, 32'hCAFE_F00D);
    check("toack_err", mem_err, 0);
`else
    check("no_to_mem_err", mem_err, 0);
`endif

    // Reset pulsed asynchronously during WAIT_ACK
    drive_op(1, 0, 1, 1, 4'd1, 32'h0000_0600, 32'h0);
    step();
    ex_valid = 0;
    check("ar_req_before", dmem_req, 1);
    #2 rst = 1;
    #1;
    check("ar_req", dmem_req, 0);
    check("ar_wb_valid", wb_valid, 0);
    check("ar_mem_err", mem_err, 0);
    check("ar_addr", dmem_addr, 0);
    #2 rst = 0;
    #1;
    check("ar_ex_ready", ex_ready, 1);
    step();
    check("ar_abandoned", dmem_req, 0);
    check("ar_ex_ready2", ex_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
